// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs the imem req/ack handshake, feeds IF/ID,
// composes the pipeline stall vector and applies branch/exception redirects.
//
// state | meaning
// IDLE  | post-reset, no request outstanding; moves to REQ next edge
// REQ   | imem_req high, imem_addr = pc held until imem_ack
// HOLD  | fetched word parked in buf_inst/buf_pc while IF is stalled
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h00000000,
  parameter logic [31:0] EXC_VEC   = 32'h00000020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_req_id,
  input  logic        stall_req_ex,
  input  logic        stall_req_mem,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [5:0]  stall,
  output logic        flush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        kill, kill_n;
  logic        kill_exc, kill_exc_n;
  logic [31:0] tgt, tgt_n;
  logic [31:0] buf_inst, buf_inst_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic        if_valid_n;
  logic [31:0] if_inst_n, if_pc_n;
  logic        flush_n;

  logic        stall_if;
  logic        redirect;
  logic [31:0] redir_tgt;
  logic [31:0] kill_tgt;

  assign stall_if  = stall_req_id | stall_req_ex | stall_req_mem;
  assign redirect  = br_valid | exc_valid;
  assign redir_tgt = exc_valid ? EXC_VEC : br_target;

  // Where the PC goes when a killed fetch finally acks; a same-cycle redirect
  // still counts, but a branch may not displace a pending exception target.
  always_comb begin
    kill_tgt = tgt;
    if (exc_valid) begin
      kill_tgt = EXC_VEC;
    end else if (br_valid && !kill_exc) begin
      kill_tgt = br_target;
    end
  end

  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc;

  always_comb begin
    stall = 6'b000000;
    if (!rst) begin
      if (stall_req_mem) begin
        stall = 6'b011111;
      end else if (stall_req_ex) begin
        stall = 6'b001111;
      end else if (stall_req_id) begin
        stall = 6'b000111;
      end else if ((state == REQ) && !imem_ack) begin
        stall = 6'b000011;
      end
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    kill_n     = kill;
    kill_exc_n = kill_exc;
    tgt_n      = tgt;
    buf_inst_n = buf_inst;
    buf_pc_n   = buf_pc;
    if_valid_n = 1'b0;
    if_inst_n  = if_inst;
    if_pc_n    = if_pc;
    flush_n    = exc_valid;

    case (state)
      IDLE: begin
        state_n = REQ;
        if (redirect) begin
          pc_n = redir_tgt;
        end
      end

      REQ: begin
        if (imem_ack) begin
          if (kill) begin
            pc_n       = kill_tgt;
            kill_n     = 1'b0;
            kill_exc_n = 1'b0;
          end else if (redirect) begin
            pc_n = redir_tgt;
          end else begin
            pc_n = pc + 32'd4;
            if (stall_if) begin
              buf_inst_n = imem_rdata;
              buf_pc_n   = pc;
              state_n    = HOLD;
            end else begin
              if_valid_n = 1'b1;
              if_inst_n  = imem_rdata;
              if_pc_n    = pc;
            end
          end
        end else if (redirect) begin
          // Address must stay put until ack, so the redirect is deferred.
          if (!kill) begin
            kill_n     = 1'b1;
            tgt_n      = redir_tgt;
            kill_exc_n = exc_valid;
          end else if (exc_valid) begin
            tgt_n      = EXC_VEC;
            kill_exc_n = 1'b1;
          end else if (!kill_exc) begin
            tgt_n = br_target;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_n    = redir_tgt;
          state_n = REQ;
        end else if (!stall_if) begin
          if_valid_n = 1'b1;
          if_inst_n  = buf_inst;
          if_pc_n    = buf_pc;
          state_n    = REQ;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (exc_valid) begin
      if_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_VEC;
      kill     <= 1'b0;
      kill_exc <= 1'b0;
      tgt      <= 32'h0;
      buf_inst <= 32'h0;
      buf_pc   <= 32'h0;
      if_valid <= 1'b0;
      if_inst  <= 32'h0;
      if_pc    <= 32'h0;
      flush    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      kill     <= kill_n;
      kill_exc <= kill_exc_n;
      tgt      <= tgt_n;
      buf_inst <= buf_inst_n;
      buf_pc   <= buf_pc_n;
      if_valid <= if_valid_n;
      if_inst  <= if_inst_n;
      if_pc    <= if_pc_n;
      flush    <= flush_n;
    end
  end

endmodule
